// File: rtl/conv_pkg.sv
// Shared types and helpers for the N x M convolution engine: FSM states,
// drain depth, and the signed clamp used for saturating writeback.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  localparam int DRAIN_CYCLES = 3;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [127:0] sat_clamp(input logic signed [127:0] v,
                                                    input int unsigned w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// MAC datapath: registered product one cycle after rdata, accumulate the next cycle.
// Optional CONV_SATURATE_EN clamps the accumulator on writeback, otherwise truncates.
module conv_mac_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     en_s,
  input  logic                     tap_vld,
  input  logic                     tap_first,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] y_data,
  output logic [OUT_W-1:0]         result
);
  import conv_pkg::*;

  logic                         s1_vld, s1_first;
  logic                         p_vld, p_first;
  logic signed [2*DATA_W-1:0]   prod_q;
  logic signed [ACC_W-1:0]      acc;

  // s1 aligns with RAM read data; p aligns with the registered product.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      p_vld    <= 1'b0;
      p_first  <= 1'b0;
      prod_q   <= '0;
      acc      <= '0;
    end else if (en_s) begin
      s1_vld   <= tap_vld;
      s1_first <= tap_first;
      p_vld    <= s1_vld;
      p_first  <= s1_first;
      if (s1_vld)
        prod_q <= (2*DATA_W)'(x_data) * (2*DATA_W)'(y_data);
      if (p_vld)
        acc <= p_first ? ACC_W'(prod_q) : acc + ACC_W'(prod_q);
    end
  end

`ifdef CONV_SATURATE_EN
  assign result = OUT_W'(sat_clamp(128'(acc), OUT_W));
`else
  assign result = acc[OUT_W-1:0];
`endif

endmodule

// File: rtl/conv_engine_nxm.sv
// 1-D convolution Z = X*Y over runtime sizes: FSM, address generation, MAC pipe.
// Optional CONV_SATURATE_EN selects saturating writeback (see conv_mac_pipe).
module conv_engine_nxm #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int AX_W   = 6,
  parameter int AY_W   = 6,
  parameter int AZ_W   = 7
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              en_s,
  input  logic              start,
  input  logic [AX_W:0]     size_x,
  input  logic [AY_W:0]     size_y,
  output logic [AX_W-1:0]   x_addr,
  output logic              x_re,
  input  logic [DATA_W-1:0] x_rdata,
  output logic [AY_W-1:0]   y_addr,
  output logic              y_re,
  input  logic [DATA_W-1:0] y_rdata,
  output logic [AZ_W-1:0]   z_addr,
  output logic              z_we,
  output logic [OUT_W-1:0]  z_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import conv_pkg::*;

  localparam int CW = AZ_W + 2;

  state_t          state, state_nxt;
  logic [AX_W:0]   nx_q;
  logic [AY_W:0]   ny_q;
  logic [AZ_W-1:0] n_q, n_nxt;
  logic [AX_W-1:0] k_q, k_nxt;
  logic [1:0]      dcnt_q, dcnt_nxt;
  logic            accept, size_bad, last_tap, last_n;

  function automatic logic [AX_W-1:0] kmin_of(input logic [AZ_W-1:0] n,
                                               input logic [AY_W:0]   ny);
    logic [CW-1:0] n1;
    n1 = CW'(n) + CW'(1);
    return (n1 > CW'(ny)) ? AX_W'(n1 - CW'(ny)) : '0;
  endfunction

  function automatic logic [AX_W-1:0] kmax_of(input logic [AZ_W-1:0] n,
                                               input logic [AX_W:0]   nx);
    return (CW'(n) < CW'(nx)) ? AX_W'(n) : AX_W'(nx - (AX_W+1)'(1));
  endfunction

  assign accept   = (state == IDLE) && start;
  assign size_bad = (size_x == '0) || (size_y == '0) ||
                    (size_x > {1'b1, {AX_W{1'b0}}}) || (size_y > {1'b1, {AY_W{1'b0}}});
  assign last_tap = (k_q == kmax_of(n_q, nx_q));
  assign last_n   = (CW'(n_q) == CW'(nx_q) + CW'(ny_q) - CW'(2));

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state  <= IDLE;
      n_q    <= '0;
      k_q    <= '0;
      dcnt_q <= '0;
      nx_q   <= '0;
      ny_q   <= '0;
      err    <= 1'b0;
    end else if (en_s) begin
      state  <= state_nxt;
      n_q    <= n_nxt;
      k_q    <= k_nxt;
      dcnt_q <= dcnt_nxt;
      if (accept) begin
        nx_q <= size_x;
        ny_q <= size_y;
        err  <= size_bad;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n_q;
    k_nxt     = k_q;
    dcnt_nxt  = dcnt_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = size_bad ? FIN : ISSUE;
          n_nxt     = '0;
          k_nxt     = '0;
        end
      end
      ISSUE: begin
        if (last_tap) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else begin
          k_nxt = k_q + AX_W'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == 2'(DRAIN_CYCLES - 1)) state_nxt = WRITE;
        else dcnt_nxt = dcnt_q + 2'd1;
      end
      WRITE: begin
        if (last_n) begin
          state_nxt = FIN;
        end else begin
          state_nxt = ISSUE;
          n_nxt     = n_q + AZ_W'(1);
          k_nxt     = kmin_of(n_q + AZ_W'(1), ny_q);
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes drop while stalled so the RAMs keep their read data.
  assign x_re   = en_s && (state == ISSUE);
  assign y_re   = en_s && (state == ISSUE);
  assign z_we   = en_s && (state == WRITE);
  assign x_addr = k_q;
  assign y_addr = AY_W'(n_q - AZ_W'(k_q));
  assign z_addr = n_q;
  assign busy   = (state == ISSUE) || (state == DRAIN) || (state == WRITE);
  assign done   = (state == FIN);

  conv_mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk       (clk),
    .rst_a     (rst_a),
    .en_s      (en_s),
    .tap_vld   (state == ISSUE),
    .tap_first (k_q == kmin_of(n_q, ny_q)),
    .x_data    ($signed(x_rdata)),
    .y_data    ($signed(y_rdata)),
    .result    (z_wdata)
  );

endmodule

// File: tb/tb_conv_engine_nxm.sv
// Directed bench for conv_engine_nxm with behavioural RAMs and a Z scoreboard.
module tb_conv_engine_nxm;

  logic        clk = 1'b0;
  logic        rst_a, en_s, start;
  logic [6:0]  size_x, size_y;
  logic [5:0]  x_addr, y_addr;
  logic        x_re, y_re, z_we, busy, done, err;
  logic signed [15:0] x_rdata, y_rdata;
  logic [6:0]  z_addr;
  logic [31:0] z_wdata;

  logic signed [15:0] x_mem [64];
  logic signed [15:0] y_mem [64];
  logic [31:0]        z_mem [128];

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int busy_cnt, wr_cnt, re_cnt;
  bit done_seen, prev_we;
  bit found;

  conv_engine_nxm dut (
    .clk     (clk),
    .rst_a   (rst_a),
    .en_s    (en_s),
    .start   (start),
    .size_x  (size_x),
    .size_y  (size_y),
    .x_addr  (x_addr),
    .x_re    (x_re),
    .x_rdata (x_rdata),
    .y_addr  (y_addr),
    .y_re    (y_re),
    .y_rdata (y_rdata),
    .z_addr  (z_addr),
    .z_we    (z_we),
    .z_wdata (z_wdata),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (x_re) x_rdata <= x_mem[x_addr];
    if (y_re) y_rdata <= y_mem[y_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (x_re || y_re) re_cnt++;
    if (z_we) begin
      wr_cnt++;
      z_mem[z_addr] = z_wdata;
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("z_addr", z_addr, e.addr);
        check("z_data", z_wdata, e.data);
      end
    end
    if (done) begin
      done_seen = 1'b1;
      if (!err) begin
        check("done_after_we", prev_we, 1);
        check("busy_at_done", busy, 0);
      end
    end
    prev_we = z_we;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int nx, input int ny);
    for (int n = 0; n <= nx + ny - 2; n++) begin
      longint s;
      logic [31:0] w;
      exp_t e;
      s = 0;
      for (int k = 0; k < nx; k++)
        if (n - k >= 0 && n - k < ny) s += longint'(x_mem[k]) * longint'(y_mem[n - k]);
`ifdef CONV_SATURATE_EN
      if (s > 64'sd2147483647) w = 32'h7FFF_FFFF;
      else if (s < -64'sd2147483648) w = 32'h8000_0000;
      else w = s[31:0];
`else
      w = s[31:0];
`endif
      e.addr = 7'(n);
      e.data = w;
      sb.push_back(e);
    end
  endtask

  task automatic kick(input int nx, input int ny);
    push_model(nx, ny);
    foreach (z_mem[i]) z_mem[i] = '0;
    busy_cnt  = 0;
    wr_cnt    = 0;
    re_cnt    = 0;
    done_seen = 1'b0;
    size_x = 7'(nx);
    size_y = 7'(ny);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic finish(input string tag, input int exp_busy, input int exp_wr);
    for (int i = 0; i < 3000 && !done_seen; i++) tick();
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_writes"}, wr_cnt, exp_wr);
    check({tag, "_sb_drained"}, sb.size(), 0);
    tick();
  endtask

  initial begin
    rst_a = 1'b0;
    en_s  = 1'b1;
    start = 1'b0;
    size_x = '0;
    size_y = '0;
    prev_we = 1'b0;
    busy_cnt = 0; wr_cnt = 0; re_cnt = 0; done_seen = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_strobes", {x_re, y_re, z_we}, 0);
    check("rst_addrs", {x_addr, y_addr, z_addr}, 0);
    check("rst_wdata", z_wdata, 0);
    tick();
    rst_a = 1'b1;
    tick();

    // 10x5 ramp
    for (int i = 0; i < 10; i++) x_mem[i] = 16'(i + 1);
    for (int i = 0; i < 5; i++)  y_mem[i] = 16'(i + 1);
    kick(10, 5);
    finish("r10x5", 106, 14);
    check("z0", z_mem[0], 1);
    check("z1", z_mem[1], 4);
    check("z4", z_mem[4], 35);
    check("z13", z_mem[13], 50);

    // size error, then a valid 1x1 start clears err
    re_cnt = 0; wr_cnt = 0; busy_cnt = 0;
    size_x = 7'd0; size_y = 7'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("errpath_err", err, 1);
    check("errpath_done", done, 1);
    check("errpath_busy", busy, 0);
    tick();
    check("errpath_done_pulse", done, 0);
    check("errpath_err_sticky", err, 1);
    repeat (3) tick();
    check("errpath_no_reads", re_cnt, 0);
    check("errpath_no_writes", wr_cnt, 0);
    check("errpath_no_busy", busy_cnt, 0);

    x_mem[0] = -16'sd3;
    y_mem[0] = 16'sd7;
    kick(1, 1);
    check("err_cleared", err, 0);
    finish("r1x1", 5, 1);
    check("z0_neg", z_mem[0], 32'hFFFF_FFEB);

    // large operands: saturation vs truncation of Z[3]
    for (int i = 0; i < 4; i++) begin
      x_mem[i] = 16'sh7FFF;
      y_mem[i] = 16'sh7FFF;
    end
    kick(4, 4);
    finish("r4x4", 44, 7);
`ifdef CONV_SATURATE_EN
    check("z3_big", z_mem[3], 32'h7FFF_FFFF);
`else
    check("z3_big", z_mem[3], 32'hFFFC_0004);
`endif

    // 10x5 with a 5-cycle enable stall mid-issue
    for (int i = 0; i < 10; i++) x_mem[i] = 16'(i + 1);
    for (int i = 0; i < 5; i++)  y_mem[i] = 16'(i + 1);
    kick(10, 5);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (x_re && x_addr == 6'd1) found = 1'b1;
      else tick();
    end
    check("stall_point_found", found, 1);
    en_s = 1'b0;
    repeat (5) tick();
    en_s = 1'b1;
    finish("stall", 111, 14);
    check("stall_z4", z_mem[4], 35);

    // reset mid-run, then a clean run with an ignored second start
    kick(10, 5);
    repeat (38) tick();
    rst_a = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_we", z_we, 0);
    sb.delete();
    wr_cnt = 0;
    tick();
    check("midrst_no_writes", wr_cnt, 0);
    rst_a = 1'b1;
    tick();
    kick(10, 5);
    repeat (20) tick();
    size_x = 7'd3;
    size_y = 7'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    finish("rerun", 106, 14);
    check("rerun_z13", z_mem[13], 50);
    check("rerun_z1", z_mem[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
